// File: rtl/j11bus_pkg.sv
// Shared definitions for the J11 bus router: GP codes, FSM states and target-select encoding.
package j11bus_pkg;

  localparam logic [7:0] GP_RD_PWR   = 8'o000;
  localparam logic [7:0] GP_BRST_SET = 8'o014;
  localparam logic [7:0] GP_BRST_CLR = 8'o214;
  localparam logic [7:0] GP_ODT_SET  = 8'o034;
  localparam logic [7:0] GP_ODT_CLR  = 8'o234;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef enum logic [1:0] {SEL_MEM, SEL_SLV, SEL_GP, SEL_NONE} sel_e;

endpackage

// File: rtl/j11bus_router_if.sv
// J11 front-end bus cycle handshake: request/address/data in, ack/error/read data out.
interface j11bus_router_if #(
  parameter int AW = 22,
  parameter int DW = 16
) ();
  logic          busreq;
  logic          buswr;
  logic          busgp;
  logic [AW-1:0] busaddr;
  logic [DW-1:0] buswdata;
  logic          busack;
  logic          buserr;
  logic [DW-1:0] busrdata;

  modport master (output busreq, buswr, busgp, busaddr, buswdata,
                  input  busack, buserr, busrdata);
  modport slave  (input  busreq, buswr, busgp, busaddr, buswdata,
                  output busack, buserr, busrdata);
endinterface

// File: rtl/j11bus_decode.sv
// Combinational target decode: GP, memory, first matching I/O-page window, or unmapped.
module j11bus_decode
  import j11bus_pkg::*;
#(
  parameter int                 AW       = 22,
  parameter int                 NSLAVE   = 4,
  parameter logic [AW-1:0]      IOBASE   = 22'o17760000,
  parameter logic [NSLAVE*13-1:0] SLV_BASE = {13'o17570, 13'o17560, 13'o17550, 13'o17540},
  parameter logic [NSLAVE*13-1:0] SLV_MASK = {NSLAVE{13'o17770}}
) (
  input  logic [AW-1:0]     addr,
  input  logic              gp,
  output logic [NSLAVE-1:0] slv_hit,
  output sel_e              target
);

  logic io;
  logic found;

  always_comb begin
    io      = (addr >= IOBASE);
    found   = 1'b0;
    slv_hit = '0;
    // Scan upward and stop at the first hit so overlapping windows resolve to the lowest index.
    for (int i = 0; i < NSLAVE; i++) begin
      if (!found && io &&
          ((addr[12:0] & SLV_MASK[13*i +: 13]) == (SLV_BASE[13*i +: 13] & SLV_MASK[13*i +: 13]))) begin
        slv_hit[i] = 1'b1;
        found      = 1'b1;
      end
    end
    target = SEL_NONE;
    if (gp)         target = SEL_GP;
    else if (!io)   target = SEL_MEM;
    else if (found) target = SEL_SLV;
  end

endmodule

// File: rtl/j11bus_router.sv
// Routes one J11 bus cycle at a time to memory or an I/O-page peripheral, serves GP cycles
// locally and bus-errors unmapped or unacknowledged cycles.
//   state | meaning
//   IDLE  | no cycle outstanding; busreq accepted here
//   WAIT  | request issued to memory/peripheral; waiting for its ack or timeout
module j11bus_router
  import j11bus_pkg::*;
#(
  parameter int                   AW       = 22,
  parameter int                   DW       = 16,
  parameter int                   NSLAVE   = 4,
  parameter logic [AW-1:0]        IOBASE   = 22'o17760000,
  parameter logic [NSLAVE*13-1:0] SLV_BASE = {13'o17570, 13'o17560, 13'o17550, 13'o17540},
  parameter logic [NSLAVE*13-1:0] SLV_MASK = {NSLAVE{13'o17770}},
  parameter int                   TIMEOUT  = 64,
  parameter logic [DW-1:0]        POWERUP  = 16'o5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  j11bus_router_if.slave       bus,
  output logic                 busrst,
  output logic                 odt,
  output logic                 memreq,
  input  logic                 memack,
  input  logic [DW-1:0]        memrdata,
  output logic [NSLAVE-1:0]    slvreq,
  input  logic [NSLAVE-1:0]    slvack,
  input  logic [NSLAVE*DW-1:0] slvrdata,
  output logic [AW-1:0]        devaddr,
  output logic                 devwr,
  output logic [DW-1:0]        devwdata
);

  localparam int            TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);

  state_e            state, state_n;
  sel_e              tgt, tgt_n, target;
  logic [NSLAVE-1:0] slv_sel, slv_sel_n, slv_hit, slvreq_n;
  logic [TW-1:0]     timer, timer_n;
  logic              take, ack_q, ack_n, err_q, err_n, brst_n, odt_n, memreq_n;
  logic              tgt_ack;
  logic [DW-1:0]     rdata_q, rdata_n, slv_rdata, tgt_rdata;

  j11bus_decode #(
    .AW(AW), .NSLAVE(NSLAVE), .IOBASE(IOBASE), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_decode (
    .addr(bus.busaddr), .gp(bus.busgp), .slv_hit(slv_hit), .target(target)
  );

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NSLAVE; i++)
      if (slv_sel[i]) slv_rdata = slv_rdata | slvrdata[DW*i +: DW];
  end

  always_comb begin
    state_n   = state;
    tgt_n     = tgt;
    slv_sel_n = slv_sel;
    timer_n   = timer;
    take      = 1'b0;
    ack_n     = 1'b0;
    err_n     = 1'b0;
    rdata_n   = rdata_q;
    brst_n    = busrst;
    odt_n     = odt;
    memreq_n  = 1'b0;
    slvreq_n  = '0;
    tgt_ack   = (tgt == SEL_MEM) ? memack : |(slvack & slv_sel);
    tgt_rdata = (tgt == SEL_MEM) ? memrdata : slv_rdata;
    case (state)
      IDLE: if (bus.busreq) begin
        take      = 1'b1;
        tgt_n     = target;
        slv_sel_n = slv_hit;
        timer_n   = TLOAD;
        case (target)
          SEL_GP: begin
            ack_n = 1'b1;
            if (bus.buswr) begin
              case (bus.busaddr[7:0])
                GP_BRST_SET: brst_n = 1'b1;
                GP_BRST_CLR: brst_n = 1'b0;
                GP_ODT_SET:  odt_n  = 1'b1;
                GP_ODT_CLR:  odt_n  = 1'b0;
                default: ;
              endcase
            end else begin
              rdata_n = (bus.busaddr[7:0] == GP_RD_PWR) ? POWERUP : '0;
            end
          end
          SEL_MEM: begin
            memreq_n = 1'b1;
            state_n  = WAIT;
          end
          SEL_SLV: begin
            slvreq_n = slv_hit;
            state_n  = WAIT;
          end
          default: begin
            ack_n = 1'b1;
            err_n = 1'b1;
          end
        endcase
      end
      WAIT: begin
        // An ack in the expiry cycle takes priority over the timeout error.
        if (tgt_ack) begin
          ack_n   = 1'b1;
          rdata_n = tgt_rdata;
          state_n = IDLE;
        end else if (timer == '0) begin
          ack_n   = 1'b1;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tgt      <= SEL_NONE;
      slv_sel  <= '0;
      timer    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      busrst   <= 1'b1;
      odt      <= 1'b0;
      memreq   <= 1'b0;
      slvreq   <= '0;
      devaddr  <= '0;
      devwr    <= 1'b0;
      devwdata <= '0;
    end else begin
      state   <= state_n;
      tgt     <= tgt_n;
      slv_sel <= slv_sel_n;
      timer   <= timer_n;
      ack_q   <= ack_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
      busrst  <= brst_n;
      odt     <= odt_n;
      memreq  <= memreq_n;
      slvreq  <= slvreq_n;
      if (take) begin
        devaddr  <= bus.busaddr;
        devwr    <= bus.buswr;
        devwdata <= bus.buswdata;
      end
    end
  end

  assign bus.busack   = ack_q;
  assign bus.buserr   = err_q;
  assign bus.busrdata = rdata_q;

endmodule

// File: tb/tb_j11bus_router.sv
// Directed scoreboard bench for j11bus_router: GP, memory, slave, unmapped, timeout and reset cases.
module tb_j11bus_router;

  logic        clk;
  logic        rst_n;
  logic        busrst, odt, memreq, memack, devwr;
  logic [15:0] memrdata, devwdata;
  logic [3:0]  slvreq, slvack;
  logic [63:0] slvrdata;
  logic [21:0] devaddr;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  j11bus_router_if #(.AW(22), .DW(16)) bif ();

  j11bus_router #(
    .AW(22), .DW(16), .NSLAVE(4), .IOBASE(22'o17760000),
    .SLV_BASE({13'o16000, 13'o17600, 13'o17560, 13'o17560}),
    .SLV_MASK({13'o17700, 13'o17770, 13'o17770, 13'o17770}),
    .TIMEOUT(64), .POWERUP(16'o5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .busrst(busrst), .odt(odt),
    .memreq(memreq), .memack(memack), .memrdata(memrdata),
    .slvreq(slvreq), .slvack(slvack), .slvrdata(slvrdata),
    .devaddr(devaddr), .devwr(devwr), .devwdata(devwdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and retire one-cycle input strobes.
  task automatic tick();
    @(negedge clk);
    bif.busreq = 1'b0;
    memack     = 1'b0;
    slvack     = '0;
  endtask

  task automatic issue(input logic wr, input logic gp, input logic [21:0] addr, input logic [15:0] wd);
    bif.busreq   = 1'b1;
    bif.buswr    = wr;
    bif.busgp    = gp;
    bif.busaddr  = addr;
    bif.buswdata = wd;
  endtask

  task automatic expect_resp(input logic err, input logic [15:0] rd);
    sb.push_back('{err, rd});
  endtask

  task automatic wait_ack(input int lat, input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      tick();
      n++;
    end while (bif.busack !== 1'b1 && n < lat + 4);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_ack"}, bif.busack, 1'b1);
    if (bif.busack === 1'b1) begin
      chk({tag, "_sb"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_err"}, bif.buserr, e.err);
        chk({tag, "_rdata"}, bif.busrdata, e.rdata);
      end
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | (bif.busack === 1'b1);
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bif.busreq   = 1'b0;
    bif.buswr    = 1'b0;
    bif.busgp    = 1'b0;
    bif.busaddr  = '0;
    bif.buswdata = '0;
    memack       = 1'b0;
    memrdata     = '0;
    slvack       = '0;
    slvrdata     = {16'o3333, 16'o2222, 16'o4444, 16'o1111};

    tick();
    tick();
    chk("rst_busack", bif.busack, 1'b0);
    chk("rst_buserr", bif.buserr, 1'b0);
    chk("rst_rdata", bif.busrdata, 16'h0);
    chk("rst_busrst", busrst, 1'b1);
    chk("rst_odt", odt, 1'b0);
    chk("rst_memreq", memreq, 1'b0);
    chk("rst_slvreq", slvreq, 4'h0);
    chk("rst_devaddr", devaddr, 22'h0);
    rst_n = 1'b1;
    tick();

    // GP cycles
    issue(1'b0, 1'b1, 22'o000, 16'h0); expect_resp(1'b0, 16'o5); wait_ack(1, "gp_rd000");
    issue(1'b1, 1'b1, 22'o214, 16'h0); expect_resp(1'b0, 16'o5); wait_ack(1, "gp_wr214");
    chk("gp_busrst_clr", busrst, 1'b0);
    issue(1'b1, 1'b1, 22'o034, 16'h0); expect_resp(1'b0, 16'o5); wait_ack(1, "gp_wr034");
    chk("gp_odt_set", odt, 1'b1);
    issue(1'b1, 1'b1, 22'o014, 16'h0); expect_resp(1'b0, 16'o5); wait_ack(1, "gp_wr014");
    chk("gp_busrst_set", busrst, 1'b1);
    issue(1'b1, 1'b1, 22'o234, 16'h0); expect_resp(1'b0, 16'o5); wait_ack(1, "gp_wr234");
    chk("gp_odt_clr", odt, 1'b0);
    issue(1'b1, 1'b1, 22'o077, 16'h0); expect_resp(1'b0, 16'o5); wait_ack(1, "gp_wr077");
    chk("gp_other_busrst", busrst, 1'b1);
    chk("gp_other_odt", odt, 1'b0);
    issue(1'b0, 1'b1, 22'o001, 16'h0); expect_resp(1'b0, 16'h0); wait_ack(1, "gp_rd001");

    // Memory read, memack 3 cycles after memreq; a busreq during WAIT is ignored
    issue(1'b0, 1'b0, 22'o001000, 16'h0);
    tick();
    chk("mem_req", memreq, 1'b1);
    chk("mem_slvreq", slvreq, 4'h0);
    tick();
    chk("mem_req_pulse", memreq, 1'b0);
    issue(1'b0, 1'b1, 22'o000, 16'h0);
    tick();
    tick();
    chk("mem_devaddr", devaddr, 22'o001000);
    chk("mem_devwr", devwr, 1'b0);
    memack = 1'b1; memrdata = 16'o123456;
    expect_resp(1'b0, 16'o123456); wait_ack(1, "mem_rd");
    quiet(3, "mem_single_ack");

    // Overlapping windows: slave0 wins; a non-selected ack is ignored
    issue(1'b0, 1'b0, 22'o17777562, 16'h0);
    tick();
    chk("s0_slvreq", slvreq, 4'b0001);
    chk("s0_memreq", memreq, 1'b0);
    slvack = 4'b0010;
    tick();
    chk("s0_other_ack", bif.busack, 1'b0);
    chk("s0_devaddr_hold", devaddr, 22'o17777562);
    slvack = 4'b0001;
    expect_resp(1'b0, 16'o1111); wait_ack(1, "s0_rd");
    chk("s0_devaddr_ack", devaddr, 22'o17777562);

    // Slave2 write acked in the request cycle
    issue(1'b1, 1'b0, 22'o17777600, 16'hbeef);
    tick();
    chk("s2_slvreq", slvreq, 4'b0100);
    chk("s2_devwr", devwr, 1'b1);
    chk("s2_devwdata", devwdata, 16'hbeef);
    slvack = 4'b0100;
    expect_resp(1'b0, 16'o2222); wait_ack(1, "s2_wr");

    // Unmapped I/O address
    issue(1'b0, 1'b0, 22'o17770000, 16'h0);
    expect_resp(1'b1, 16'o2222); wait_ack(1, "unmapped");
    chk("unm_memreq", memreq, 1'b0);
    chk("unm_slvreq", slvreq, 4'h0);

    // Timeout on slave3, then a late ack 5 cycles later
    issue(1'b0, 1'b0, 22'o17776000, 16'h0);
    tick();
    chk("to_slvreq", slvreq, 4'b1000);
    expect_resp(1'b1, 16'o2222); wait_ack(64, "timeout");
    for (int i = 0; i < 4; i++) tick();
    slvack = 4'b1000;
    quiet(4, "late_ack");

    // Ack in the same cycle as expiry wins
    issue(1'b0, 1'b0, 22'o002000, 16'h0);
    tick();
    chk("exp_memreq", memreq, 1'b1);
    for (int i = 0; i < 63; i++) tick();
    memack = 1'b1; memrdata = 16'o7070;
    expect_resp(1'b0, 16'o7070); wait_ack(1, "ack_at_expiry");

    // Reset in WAIT abandons the cycle
    issue(1'b1, 1'b1, 22'o034, 16'h0); expect_resp(1'b0, 16'o7070); wait_ack(1, "pre_odt");
    issue(1'b1, 1'b1, 22'o214, 16'h0); expect_resp(1'b0, 16'o7070); wait_ack(1, "pre_brst");
    issue(1'b0, 1'b0, 22'o003000, 16'h0);
    tick();
    chk("rw_memreq", memreq, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rw_busrst", busrst, 1'b1);
    chk("rw_odt", odt, 1'b0);
    chk("rw_busack", bif.busack, 1'b0);
    chk("rw_devaddr", devaddr, 22'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    memack = 1'b1; memrdata = 16'o5555;
    quiet(4, "rw_no_ack");
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/j11bus_router.md
Name: j11bus_router

Overview:
Parametrised successor to the single-memory/single-UART DCJ11 bus decoder. It routes each J11 bus cycle to main memory or to one of NSLAVE I/O-page peripherals, using configurable address windows. It services J11 general-purpose (GP) cycles locally and terminates unacknowledged cycles with a bus error after a programmable timeout. It sits between the J11 bus front-end and the memory controller and peripheral blocks; one cycle is outstanding at a time.

Parameters:
AW, 22, bus address width
DW, 16, data width
NSLAVE, 4, number of I/O-page peripheral ports
IOBASE, 22'o17760000, first I/O-page address; addresses below it go to memory
SLV_BASE, NSLAVE*13 bits, per-slave base within I/O page (busaddr[12:0]); slave i occupies bits [13*i+:13]
SLV_MASK, NSLAVE*13 bits, per-slave compare mask; 1 = bit compared
TIMEOUT, 64, cycles to wait for a target ack before bus error; must be >=2
POWERUP, 16'o5, value returned by a GP read at code 0o000

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
busreq  in  1  one-cycle cycle-start strobe from front-end
buswr  in  1  1 = write
busgp  in  1  1 = GP cycle
busaddr  in  AW  address (GP code in [7:0])
buswdata  in  DW  write data
busack  out  1  one-cycle completion pulse
buserr  out  1  with busack: cycle failed (unmapped or timeout)
busrdata  out  DW  read data, valid with busack
busrst  out  1  bus reset line, GP-controlled
odt  out  1  ODT state, GP-controlled
memreq  out  1  one-cycle request to memory
memack  in  1  memory completion
memrdata  in  DW  memory read data
slvreq  out  NSLAVE  one-hot one-cycle request to peripheral
slvack  in  NSLAVE  peripheral completions
slvrdata  in  NSLAVE*DW  peripheral read data, slave i at [DW*i+:DW]
devaddr  out  AW  latched address to all targets
devwr  out  1  latched write flag
devwdata  out  DW  latched write data

Behaviour:
- Reset (async assert, sync deassert): busack=0, buserr=0, busrdata=0, busrst=1, odt=0, memreq=0, slvreq=0, dev* = 0, state IDLE, timer=0.
- States: IDLE, WAIT. busreq is sampled only in IDLE; busreq in WAIT is ignored (no ack is generated for it).
- Accept at cycle T (IDLE & busreq): latch devaddr/devwr/devwdata and decode the target.
- GP cycle: busack=1 at T+1, buserr=0, stay IDLE.
  - Write 0o014: busrst=1. Write 0o214: busrst=0. Write 0o034: odt=1. Write 0o234: odt=0. Other writes: no effect.
  - Read 0o000: busrdata=POWERUP. Other reads: busrdata=0.
- Memory: non-GP cycle with busaddr < IOBASE. memreq pulses at T+1; go to WAIT.
- Slave: non-GP cycle with busaddr >= IOBASE and (busaddr[12:0] & mask_i) == (base_i & mask_i).
  - The lowest matching index wins.
  - slvreq[i] pulses at T+1; go to WAIT.
- Unmapped: no match. busack=1 and buserr=1 at T+1; stay IDLE.
- WAIT: the timer counts from 0, starting the cycle after the request pulse.
  - If the selected target acks at cycle A: busack=1 and busrdata=target rdata at A+1; buserr=0; go to IDLE.
  - If timer reaches TIMEOUT-1 with no ack: busack=1, buserr=1 next cycle; busrdata unchanged; go to IDLE.
  - Ack in the same cycle as expiry: the ack wins (no error).
- Acks from non-selected targets, and acks arriving in IDLE (late ack after timeout), are ignored.
- dev* hold stable from T+1 until the busack cycle.
- busack/buserr are single-cycle pulses; at most one busack per accepted cycle.
- Reset mid-WAIT: the cycle is abandoned with no ack; a target ack after reset is ignored.

Decomposition:
- Package j11bus_pkg holds:
  - GP code constants: 0o000, 0o014, 0o214, 0o034, 0o234.
  - State enum: IDLE, WAIT.
  - Target-select encoding: MEM, SLV, GP, NONE.
- Sub-module j11bus_decode: combinational. busaddr, busgp, IOBASE/SLV_BASE/SLV_MASK -> one-hot slave select, mem/gp/unmapped flags.

Test Plan:
1. GP read 0o000, then GP write 0o214 -> busack at T+1 with busrdata=16'o5; then busrst falls 1->0 the cycle after the write accept.
2. Memory read at 22'o001000, memack 3 cycles after memreq with memrdata=16'o123456 -> busack one cycle after memack, busrdata=16'o123456, buserr=0.
3. Overlapping windows: slave0 base 13'o17560 mask 13'o17770, slave1 same window; read 22'o17777562 -> only slvreq[0] pulses; devaddr=22'o17777562 held until busack.
4. Unmapped I/O read at 22'o17770000 -> busack+buserr at T+1, no memreq/slvreq pulse.
5. Slave never acks, TIMEOUT=64 -> busack+buserr exactly 64 cycles after slvreq; a late slvack 5 cycles later produces no busack.
6. rst_n asserted while in WAIT, memack 2 cycles after release -> no busack; busrst=1, odt=0 after reset.
